tag_scheduler: RTL and testbench
================================

TAG_SCHEDULER -- requirements
Module: tag_scheduler

Interface
REQ-001 SHALL have parameter NUM_TAGS, default 2, meaning the number of tag_logic instances it sequences (range 2..8).
REQ-002 SHALL have parameter STORE_ENABLED, default 1, meaning that the store stage exists (1) or is bypassed (0).
REQ-003 SHALL have parameter TAG_W, default clog2(NUM_TAGS), meaning the tag-id width.
REQ-004 SHALL have clk, input, 1, meaning the single clock; one clock domain; reset is synchronous and active-low.
REQ-005 SHALL have reset_n, input, 1, meaning synchronous active-low reset.
REQ-006 SHALL have block_req, input, 1, meaning a new-tile tag request from the decoder.
REQ-007 SHALL have block_reuse, input, 1, meaning reuse of the last allocated tag.
REQ-008 SHALL have block_flush, input, 1, meaning flush of the last allocated tag.
REQ-009 SHALL have block_ready, output, 1, meaning the allocation target tag is free.
REQ-010 SHALL have ldmem_done, compute_done and stmem_done, each input, 1, meaning stage completion pulses.
REQ-011 SHALL have ldmem_ready, compute_ready and stmem_ready, each output, 1, meaning the stage's current tag is ready.
REQ-012 SHALL have ldmem_tag, compute_tag and stmem_tag, each output, TAG_W, meaning the current tag id per stage.
REQ-013 SHALL have tag_ready_v, ldmem_tag_ready_v, compute_tag_ready_v, stmem_tag_ready_v and next_compute_tag_v, each input, NUM_TAGS, meaning per-tag status.
REQ-014 SHALL have tag_req_v, tag_reuse_v, tag_flush_v, ldmem_tag_done_v, compute_tag_done_v and stmem_tag_done_v, each output, NUM_TAGS, meaning one-hot per-tag pulses.
REQ-015 SHALL have idle, output, 1, meaning no tag outstanding.
REQ-016 SHALL have protocol_err, output, 1, meaning a sticky protocol violation.

Function
REQ-017 SHALL keep four modulo-NUM_TAGS pointers: alloc_ptr, ldmem_ptr, compute_ptr and stmem_ptr; each advances by 1 and wraps NUM_TAGS-1 -> 0.
REQ-018 SHALL drive block_ready = tag_ready_v[alloc_ptr], ldmem_ready = ldmem_tag_ready_v[ldmem_ptr], compute_ready = compute_tag_ready_v[compute_ptr] and stmem_ready = stmem_tag_ready_v[stmem_ptr], all combinationally.
REQ-019 SHALL treat block_req && block_ready as accepted: next cycle tag_req_v pulses bit alloc_ptr for 1 cycle, alloc_ptr advances, and last_ptr <= old alloc_ptr.
REQ-020 SHALL ignore block_req while block_ready is 0, with no error; the requester holds block_req.
REQ-021 SHALL pulse tag_reuse_v[last_ptr] and tag_flush_v[last_ptr] one cycle after block_reuse and block_flush, respectively; if no tag has been allocated since reset, these inputs are ignored and protocol_err is set.
REQ-022 SHALL, on ldmem_done && ldmem_ready, pulse ldmem_tag_done_v[ldmem_ptr] next cycle and advance ldmem_ptr at the same edge; stmem_done && stmem_ready SHALL behave the same way with the stmem signals.
REQ-023 SHALL, on compute_done && compute_ready, pulse compute_tag_done_v[compute_ptr] next cycle without advancing compute_ptr.
REQ-024 SHALL advance compute_ptr only when next_compute_tag_v[compute_ptr] = 1, so that reuse keeps compute on the same tag.
REQ-025 SHALL, on any *_done arriving while the matching ready is 0, drop the pulse and set protocol_err; protocol_err stays set until reset.
REQ-026 SHALL, when STORE_ENABLED = 0, keep stmem_ptr fixed at 0, stmem_ready = 0 and stmem_tag_done_v = 0, and treat stmem_done as a protocol error.
REQ-027 SHALL keep outstanding count cnt (0..NUM_TAGS): +1 on an accepted request; -1 on an accepted stmem_done, or on a compute_ptr advance when STORE_ENABLED = 0; a simultaneous +1/-1 leaves cnt unchanged; idle = (cnt == 0).
REQ-028 SHALL keep all one-hot outputs registered, at most one bit per vector set per cycle, with 1-cycle latency from the qualifying input.
REQ-029 SHALL process same-cycle events on different stages independently, with no priority between them.
REQ-030 SHALL hold cnt saturated at NUM_TAGS when an overflow would occur and set protocol_err; an underflow SHALL likewise be blocked and set protocol_err.

Reset
REQ-031 SHALL, while reset_n is 0 at a clk edge, clear all pointers, last_ptr, the allocated flag, cnt, protocol_err and all one-hot outputs to 0; idle SHALL then be 1.
REQ-032 SHALL have reset mid-operation discard pulses in flight; no pulse is emitted in the cycle after reset deasserts.

Structure
REQ-033 SHALL place the TAG_W derivation, the NUM_TAGS default and the tag state encodings (FREE=0, LDMEM=1, COMPUTE=2, COMPUTE_CHECK=3, STMEM=4) in shared package genesys_tag_pkg.
REQ-034 SHALL implement each pointer as an instance of one sub-module, tag_ptr (modulo-N counter with advance input), instantiated four times.

Verification
REQ-035 SHALL cover: NUM_TAGS=2, block_req held with tag_ready_v=11 -> tag_req_v=01 then 10; alloc_ptr back to 0; cnt=2; block_ready follows tag_ready_v.
REQ-036 SHALL cover: ldmem_done with ldmem_tag_ready_v=01 -> ldmem_tag_done_v=01 next cycle, ldmem_tag 0->1; a second ldmem_done with ldmem_tag_ready_v=01 -> dropped, protocol_err=1.
REQ-037 SHALL cover: block_reuse x2, then compute_done x3 with next_compute_tag_v pulsed only after the 3rd -> compute_tag stays 0 until that pulse, then becomes 1.
REQ-038 SHALL cover: STORE_ENABLED=0, one allocate, then next_compute_tag_v=01 -> cnt 1->0, idle=1; stmem_done -> protocol_err=1.
REQ-039 SHALL cover: an accepted block_req and an accepted stmem_done in the same cycle with cnt=1 -> cnt stays 1, both pulses emitted.
REQ-040 SHALL cover: reset_n low for 1 cycle mid-sequence (cnt=2, err=1) -> all outputs 0, idle=1, err=0, no stray pulse afterward.

Source files
------------

// File: rtl/genesys_tag_pkg.sv
// Shared definitions for the tag scheduler: default tag count, tag-id width
// derivation and the per-tag lifecycle state encoding.
package genesys_tag_pkg;

  localparam int NUM_TAGS_DEF = 2;

  typedef enum logic [2:0] {
    FREE          = 3'd0,
    LDMEM         = 3'd1,
    COMPUTE       = 3'd2,
    COMPUTE_CHECK = 3'd3,
    STMEM         = 3'd4
  } tag_state_e;

  // A tag id is never narrower than one bit, even for the smallest tag count.
  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tag_ptr.sv
// Modulo-N tag pointer: advances by one on adv and wraps N-1 -> 0.
module tag_ptr
  import genesys_tag_pkg::*;
#(
  parameter int N = NUM_TAGS_DEF,
  parameter int W = tag_w(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         adv,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (ptr == W'(N - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/tag_scheduler.sv
// Sequences NUM_TAGS tag_logic instances through allocate / load / compute /
// store, emitting registered one-hot per-tag pulses and a sticky error flag.
module tag_scheduler
  import genesys_tag_pkg::*;
#(
  parameter int NUM_TAGS      = NUM_TAGS_DEF,
  parameter int STORE_ENABLED = 1,
  parameter int TAG_W         = tag_w(NUM_TAGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                block_req,
  input  logic                block_reuse,
  input  logic                block_flush,
  output logic                block_ready,
  input  logic                ldmem_done,
  input  logic                compute_done,
  input  logic                stmem_done,
  output logic                ldmem_ready,
  output logic                compute_ready,
  output logic                stmem_ready,
  output logic [TAG_W-1:0]    ldmem_tag,
  output logic [TAG_W-1:0]    compute_tag,
  output logic [TAG_W-1:0]    stmem_tag,
  input  logic [NUM_TAGS-1:0] tag_ready_v,
  input  logic [NUM_TAGS-1:0] ldmem_tag_ready_v,
  input  logic [NUM_TAGS-1:0] compute_tag_ready_v,
  input  logic [NUM_TAGS-1:0] stmem_tag_ready_v,
  input  logic [NUM_TAGS-1:0] next_compute_tag_v,
  output logic [NUM_TAGS-1:0] tag_req_v,
  output logic [NUM_TAGS-1:0] tag_reuse_v,
  output logic [NUM_TAGS-1:0] tag_flush_v,
  output logic [NUM_TAGS-1:0] ldmem_tag_done_v,
  output logic [NUM_TAGS-1:0] compute_tag_done_v,
  output logic [NUM_TAGS-1:0] stmem_tag_done_v,
  output logic                idle,
  output logic                protocol_err
);

  localparam int CNT_W = cnt_w(NUM_TAGS);

  logic [TAG_W-1:0] alloc_ptr;
  logic [TAG_W-1:0] ldmem_ptr;
  logic [TAG_W-1:0] compute_ptr;
  logic [TAG_W-1:0] stmem_ptr;
  logic [TAG_W-1:0] last_ptr;
  logic             allocated;
  logic [CNT_W-1:0] cnt;

  logic req_acc, ld_acc, cp_acc, st_acc, cp_adv;
  logic ld_err, cp_err, st_err;
  logic reuse_ok, reuse_err, flush_ok, flush_err;
  logic cnt_inc, cnt_dec, cnt_ovf, cnt_udf, err_p0;

  logic [NUM_TAGS-1:0] tag_req_p1, tag_reuse_p1, tag_flush_p1;
  logic [NUM_TAGS-1:0] ld_done_p1, cp_done_p1, st_done_p1;

  function automatic logic [NUM_TAGS-1:0] onehot(input logic [TAG_W-1:0] p);
    logic [NUM_TAGS-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Stage 0: combinational readiness and event qualification
  assign block_ready   = tag_ready_v[alloc_ptr];
  assign ldmem_ready   = ldmem_tag_ready_v[ldmem_ptr];
  assign compute_ready = compute_tag_ready_v[compute_ptr];
  assign stmem_ready   = (STORE_ENABLED != 0) ? stmem_tag_ready_v[stmem_ptr] : 1'b0;

  assign req_acc   = block_req & block_ready;
  assign ld_acc    = ldmem_done & ldmem_ready;
  assign ld_err    = ldmem_done & ~ldmem_ready;
  assign cp_acc    = compute_done & compute_ready;
  assign cp_err    = compute_done & ~compute_ready;
  assign st_acc    = stmem_done & stmem_ready;
  assign st_err    = stmem_done & ~stmem_ready;
  assign cp_adv    = next_compute_tag_v[compute_ptr];
  assign reuse_ok  = block_reuse & allocated;
  assign reuse_err = block_reuse & ~allocated;
  assign flush_ok  = block_flush & allocated;
  assign flush_err = block_flush & ~allocated;

  // Without a store stage a tag retires when compute moves past it.
  assign cnt_inc = req_acc;
  assign cnt_dec = (STORE_ENABLED != 0) ? st_acc : cp_adv;
  assign cnt_ovf = cnt_inc & ~cnt_dec & (cnt == CNT_W'(NUM_TAGS));
  assign cnt_udf = cnt_dec & ~cnt_inc & (cnt == '0);
  assign err_p0  = ld_err | cp_err | st_err | reuse_err | flush_err | cnt_ovf | cnt_udf;

  tag_ptr #(.N(NUM_TAGS), .W(TAG_W)) u_alloc_ptr (
    .clk(clk), .reset_n(reset_n), .adv(req_acc), .ptr(alloc_ptr));
  tag_ptr #(.N(NUM_TAGS), .W(TAG_W)) u_ldmem_ptr (
    .clk(clk), .reset_n(reset_n), .adv(ld_acc), .ptr(ldmem_ptr));
  tag_ptr #(.N(NUM_TAGS), .W(TAG_W)) u_compute_ptr (
    .clk(clk), .reset_n(reset_n), .adv(cp_adv), .ptr(compute_ptr));
  tag_ptr #(.N(NUM_TAGS), .W(TAG_W)) u_stmem_ptr (
    .clk(clk), .reset_n(reset_n), .adv(st_acc), .ptr(stmem_ptr));

  // Stage 1: registered pulses, allocation bookkeeping and outstanding count
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tag_req_p1   <= '0;
      tag_reuse_p1 <= '0;
      tag_flush_p1 <= '0;
      ld_done_p1   <= '0;
      cp_done_p1   <= '0;
      st_done_p1   <= '0;
      last_ptr     <= '0;
      allocated    <= 1'b0;
      cnt          <= '0;
      protocol_err <= 1'b0;
    end else begin
      tag_req_p1   <= req_acc  ? onehot(alloc_ptr)   : '0;
      tag_reuse_p1 <= reuse_ok ? onehot(last_ptr)    : '0;
      tag_flush_p1 <= flush_ok ? onehot(last_ptr)    : '0;
      ld_done_p1   <= ld_acc   ? onehot(ldmem_ptr)   : '0;
      cp_done_p1   <= cp_acc   ? onehot(compute_ptr) : '0;
      st_done_p1   <= st_acc   ? onehot(stmem_ptr)   : '0;
      if (req_acc) begin
        last_ptr  <= alloc_ptr;
        allocated <= 1'b1;
      end
      if (cnt_inc && !cnt_dec && !cnt_ovf) begin
        cnt <= cnt + 1'b1;
      end else if (cnt_dec && !cnt_inc && !cnt_udf) begin
        cnt <= cnt - 1'b1;
      end
      protocol_err <= protocol_err | err_p0;
    end
  end

  assign tag_req_v          = tag_req_p1;
  assign tag_reuse_v        = tag_reuse_p1;
  assign tag_flush_v        = tag_flush_p1;
  assign ldmem_tag_done_v   = ld_done_p1;
  assign compute_tag_done_v = cp_done_p1;
  assign stmem_tag_done_v   = st_done_p1;
  assign ldmem_tag          = ldmem_ptr;
  assign compute_tag        = compute_ptr;
  assign stmem_tag          = stmem_ptr;
  assign idle               = (cnt == '0);

endmodule

// File: tb/tb_tag_scheduler.sv
// Bench for tag_scheduler: directed scenarios plus randomized traffic checked
// against a tag-index reference model; a second instance has no store stage.
module tb_tag_scheduler;
  localparam int NT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, block_req, block_reuse, block_flush;
  logic ldmem_done, compute_done, stmem_done;
  logic [NT-1:0] tag_ready_v, ldmem_tag_ready_v, compute_tag_ready_v;
  logic [NT-1:0] stmem_tag_ready_v, next_compute_tag_v;

  logic block_ready, ldmem_ready, compute_ready, stmem_ready, idle, protocol_err;
  logic [0:0] ldmem_tag, compute_tag, stmem_tag;
  logic [NT-1:0] tag_req_v, tag_reuse_v, tag_flush_v;
  logic [NT-1:0] ldmem_tag_done_v, compute_tag_done_v, stmem_tag_done_v;

  logic block_ready_s0, ldmem_ready_s0, compute_ready_s0, stmem_ready_s0, idle_s0, protocol_err_s0;
  logic [0:0] ldmem_tag_s0, compute_tag_s0, stmem_tag_s0;
  logic [NT-1:0] tag_req_v_s0, tag_reuse_v_s0, tag_flush_v_s0;
  logic [NT-1:0] ldmem_tag_done_v_s0, compute_tag_done_v_s0, stmem_tag_done_v_s0;

  tag_scheduler #(.NUM_TAGS(NT), .STORE_ENABLED(1)) dut (
    .clk(clk), .reset_n(reset_n), .block_req(block_req), .block_reuse(block_reuse),
    .block_flush(block_flush), .block_ready(block_ready), .ldmem_done(ldmem_done),
    .compute_done(compute_done), .stmem_done(stmem_done), .ldmem_ready(ldmem_ready),
    .compute_ready(compute_ready), .stmem_ready(stmem_ready), .ldmem_tag(ldmem_tag),
    .compute_tag(compute_tag), .stmem_tag(stmem_tag), .tag_ready_v(tag_ready_v),
    .ldmem_tag_ready_v(ldmem_tag_ready_v), .compute_tag_ready_v(compute_tag_ready_v),
    .stmem_tag_ready_v(stmem_tag_ready_v), .next_compute_tag_v(next_compute_tag_v),
    .tag_req_v(tag_req_v), .tag_reuse_v(tag_reuse_v), .tag_flush_v(tag_flush_v),
    .ldmem_tag_done_v(ldmem_tag_done_v), .compute_tag_done_v(compute_tag_done_v),
    .stmem_tag_done_v(stmem_tag_done_v), .idle(idle), .protocol_err(protocol_err));

  tag_scheduler #(.NUM_TAGS(NT), .STORE_ENABLED(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .block_req(block_req), .block_reuse(block_reuse),
    .block_flush(block_flush), .block_ready(block_ready_s0), .ldmem_done(ldmem_done),
    .compute_done(compute_done), .stmem_done(stmem_done), .ldmem_ready(ldmem_ready_s0),
    .compute_ready(compute_ready_s0), .stmem_ready(stmem_ready_s0), .ldmem_tag(ldmem_tag_s0),
    .compute_tag(compute_tag_s0), .stmem_tag(stmem_tag_s0), .tag_ready_v(tag_ready_v),
    .ldmem_tag_ready_v(ldmem_tag_ready_v), .compute_tag_ready_v(compute_tag_ready_v),
    .stmem_tag_ready_v(stmem_tag_ready_v), .next_compute_tag_v(next_compute_tag_v),
    .tag_req_v(tag_req_v_s0), .tag_reuse_v(tag_reuse_v_s0), .tag_flush_v(tag_flush_v_s0),
    .ldmem_tag_done_v(ldmem_tag_done_v_s0), .compute_tag_done_v(compute_tag_done_v_s0),
    .stmem_tag_done_v(stmem_tag_done_v_s0), .idle(idle_s0), .protocol_err(protocol_err_s0));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state for the store-enabled instance, as plain tag indices.
  int m_alloc, m_ld, m_comp, m_st, m_last, m_cnt;
  bit m_any, m_err;
  logic [NT-1:0] e_req, e_reuse, e_flush, e_ld, e_cd, e_sd;

  task automatic model_reset();
    m_alloc = 0; m_ld = 0; m_comp = 0; m_st = 0; m_last = 0; m_cnt = 0;
    m_any = 0; m_err = 0;
    e_req = '0; e_reuse = '0; e_flush = '0; e_ld = '0; e_cd = '0; e_sd = '0;
  endtask

  task automatic model_step();
    int delta;
    if (!reset_n) begin
      model_reset();
      return;
    end
    e_req = '0; e_reuse = '0; e_flush = '0; e_ld = '0; e_cd = '0; e_sd = '0;
    delta = 0;
    if (block_reuse) begin
      if (m_any) e_reuse = NT'(1) << m_last; else m_err = 1;
    end
    if (block_flush) begin
      if (m_any) e_flush = NT'(1) << m_last; else m_err = 1;
    end
    if (ldmem_done) begin
      if (ldmem_tag_ready_v[m_ld]) begin e_ld = NT'(1) << m_ld; m_ld = (m_ld + 1) % NT; end
      else m_err = 1;
    end
    if (compute_done) begin
      if (compute_tag_ready_v[m_comp]) e_cd = NT'(1) << m_comp; else m_err = 1;
    end
    if (next_compute_tag_v[m_comp]) m_comp = (m_comp + 1) % NT;
    if (stmem_done) begin
      if (stmem_tag_ready_v[m_st]) begin
        e_sd = NT'(1) << m_st; m_st = (m_st + 1) % NT; delta = delta - 1;
      end else m_err = 1;
    end
    if (block_req && tag_ready_v[m_alloc]) begin
      e_req = NT'(1) << m_alloc;
      m_last = m_alloc; m_any = 1; m_alloc = (m_alloc + 1) % NT;
      delta = delta + 1;
    end
    if (m_cnt + delta > NT || m_cnt + delta < 0) m_err = 1;
    else m_cnt = m_cnt + delta;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    block_req = 0; block_reuse = 0; block_flush = 0;
    ldmem_done = 0; compute_done = 0; stmem_done = 0;
    tag_ready_v = '0; ldmem_tag_ready_v = '0; compute_tag_ready_v = '0;
    stmem_tag_ready_v = '0; next_compute_tag_v = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    tick();
    reset_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0; block_req = 1; tag_ready_v = 2'b11;
    tick();
    n_cmp++; if (tag_req_v !== 2'b00) begin n_bad++; $display("FAIL reset_req: got %b want 00", tag_req_v); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %b want 1", idle); end
    n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", protocol_err); end
    n_cmp++; if (int'(dut.cnt) !== 0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", dut.cnt); end
    n_cmp++; if ({ldmem_tag, compute_tag, stmem_tag} !== 3'b000) begin n_bad++; $display("FAIL reset_tags: got %b want 000", {ldmem_tag, compute_tag, stmem_tag}); end
    reset_n = 1; clear_inputs(); block_flush = 1;
    tick();
    n_cmp++; if (tag_flush_v !== 2'b00) begin n_bad++; $display("FAIL flush_noalloc: got %b want 00", tag_flush_v); end
    n_cmp++; if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL flush_noalloc_err: got %b want 1", protocol_err); end
  endtask

  task automatic test_alloc();
    do_reset();
    tag_ready_v = 2'b11; block_req = 1;
    #1;
    n_cmp++; if (block_ready !== 1'b1) begin n_bad++; $display("FAIL alloc_ready: got %b want 1", block_ready); end
    tick();
    n_cmp++; if (tag_req_v !== 2'b01) begin n_bad++; $display("FAIL alloc_req0: got %b want 01", tag_req_v); end
    tick();
    n_cmp++; if (tag_req_v !== 2'b10) begin n_bad++; $display("FAIL alloc_req1: got %b want 10", tag_req_v); end
    block_req = 0;
    tick();
    n_cmp++; if (tag_req_v !== 2'b00) begin n_bad++; $display("FAIL alloc_quiet: got %b want 00", tag_req_v); end
    n_cmp++; if (int'(dut.cnt) !== 2) begin n_bad++; $display("FAIL alloc_cnt: got %0d want 2", dut.cnt); end
    tag_ready_v = 2'b10; #1;
    n_cmp++; if (block_ready !== 1'b0) begin n_bad++; $display("FAIL alloc_wrap_lo: got %b want 0", block_ready); end
    tag_ready_v = 2'b01; #1;
    n_cmp++; if (block_ready !== 1'b1) begin n_bad++; $display("FAIL alloc_wrap_hi: got %b want 1", block_ready); end
  endtask

  task automatic test_ldmem();
    do_reset();
    ldmem_tag_ready_v = 2'b01; ldmem_done = 1;
    tick();
    n_cmp++; if (ldmem_tag_done_v !== 2'b01) begin n_bad++; $display("FAIL ld_done: got %b want 01", ldmem_tag_done_v); end
    n_cmp++; if (ldmem_tag !== 1'b1) begin n_bad++; $display("FAIL ld_tag: got %b want 1", ldmem_tag); end
    n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL ld_err0: got %b want 0", protocol_err); end
    tick();
    n_cmp++; if (ldmem_tag_done_v !== 2'b00) begin n_bad++; $display("FAIL ld_drop: got %b want 00", ldmem_tag_done_v); end
    n_cmp++; if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL ld_err1: got %b want 1", protocol_err); end
    n_cmp++; if (ldmem_tag !== 1'b1) begin n_bad++; $display("FAIL ld_tag_hold: got %b want 1", ldmem_tag); end
  endtask

  task automatic test_reuse();
    do_reset();
    tag_ready_v = 2'b01; block_req = 1;
    tick();
    block_req = 0; block_reuse = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (tag_reuse_v !== 2'b01) begin n_bad++; $display("FAIL reuse_%0d: got %b want 01", i, tag_reuse_v); end
    end
    block_reuse = 0; compute_tag_ready_v = 2'b01; compute_done = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (compute_tag_done_v !== 2'b01) begin n_bad++; $display("FAIL cdone_%0d: got %b want 01", i, compute_tag_done_v); end
      n_cmp++; if (compute_tag !== 1'b0) begin n_bad++; $display("FAIL ctag_hold_%0d: got %b want 0", i, compute_tag); end
    end
    compute_done = 0; next_compute_tag_v = 2'b01;
    tick();
    n_cmp++; if (compute_tag !== 1'b1) begin n_bad++; $display("FAIL ctag_adv: got %b want 1", compute_tag); end
    n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL reuse_err: got %b want 0", protocol_err); end
  endtask

  task automatic test_store_disabled();
    do_reset();
    tag_ready_v = 2'b01; block_req = 1;
    tick();
    block_req = 0;
    n_cmp++; if (int'(dut0.cnt) !== 1 || idle_s0 !== 1'b0) begin n_bad++; $display("FAIL nostore_cnt1: got %0d/%b want 1/0", dut0.cnt, idle_s0); end
    next_compute_tag_v = 2'b01;
    tick();
    next_compute_tag_v = 2'b00;
    n_cmp++; if (int'(dut0.cnt) !== 0 || idle_s0 !== 1'b1) begin n_bad++; $display("FAIL nostore_cnt0: got %0d/%b want 0/1", dut0.cnt, idle_s0); end
    n_cmp++; if (protocol_err_s0 !== 1'b0) begin n_bad++; $display("FAIL nostore_err0: got %b want 0", protocol_err_s0); end
    stmem_tag_ready_v = 2'b11; stmem_done = 1;
    #1;
    n_cmp++; if (stmem_ready_s0 !== 1'b0) begin n_bad++; $display("FAIL nostore_ready: got %b want 0", stmem_ready_s0); end
    tick();
    stmem_done = 0;
    n_cmp++; if (stmem_tag_done_v_s0 !== 2'b00 || stmem_tag_s0 !== 1'b0) begin n_bad++; $display("FAIL nostore_pulse: got %b/%b want 00/0", stmem_tag_done_v_s0, stmem_tag_s0); end
    n_cmp++; if (protocol_err_s0 !== 1'b1) begin n_bad++; $display("FAIL nostore_err1: got %b want 1", protocol_err_s0); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tag_ready_v = 2'b01; block_req = 1;
    tick();
    tag_ready_v = 2'b10; stmem_tag_ready_v = 2'b01; stmem_done = 1;
    tick();
    clear_inputs();
    n_cmp++; if (tag_req_v !== 2'b10) begin n_bad++; $display("FAIL b2b_req: got %b want 10", tag_req_v); end
    n_cmp++; if (stmem_tag_done_v !== 2'b01) begin n_bad++; $display("FAIL b2b_st: got %b want 01", stmem_tag_done_v); end
    n_cmp++; if (int'(dut.cnt) !== 1) begin n_bad++; $display("FAIL b2b_cnt: got %0d want 1", dut.cnt); end
    n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL b2b_err: got %b want 0", protocol_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tag_ready_v = 2'b11; block_req = 1;
    tick(); tick();
    block_req = 0; ldmem_done = 1;
    tick();
    ldmem_done = 0; block_reuse = 1; block_flush = 1;
    n_cmp++; if (int'(dut.cnt) !== 2 || protocol_err !== 1'b1) begin n_bad++; $display("FAIL mid_setup: got %0d/%b want 2/1", dut.cnt, protocol_err); end
    reset_n = 0;
    tick();
    n_cmp++; if ({tag_req_v, tag_reuse_v, tag_flush_v, ldmem_tag_done_v, compute_tag_done_v, stmem_tag_done_v} !== '0)
      begin n_bad++; $display("FAIL mid_pulses: got nonzero want 0"); end
    n_cmp++; if (idle !== 1'b1 || protocol_err !== 1'b0) begin n_bad++; $display("FAIL mid_state: got %b/%b want 1/0", idle, protocol_err); end
    clear_inputs(); reset_n = 1;
    tick();
    n_cmp++; if ({tag_req_v, tag_reuse_v, tag_flush_v} !== '0 || ldmem_tag !== 1'b0)
      begin n_bad++; $display("FAIL mid_stray: got %b/%b want 0/0", {tag_req_v, tag_reuse_v, tag_flush_v}, ldmem_tag); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset_n             = ($urandom_range(0, 59) != 0);
      block_req           = ($urandom_range(0, 1) == 1);
      block_reuse         = ($urandom_range(0, 9) == 0);
      block_flush         = ($urandom_range(0, 9) == 0);
      ldmem_done          = ($urandom_range(0, 2) == 0);
      compute_done        = ($urandom_range(0, 2) == 0);
      stmem_done          = ($urandom_range(0, 2) == 0);
      tag_ready_v         = NT'($urandom);
      ldmem_tag_ready_v   = NT'($urandom);
      compute_tag_ready_v = NT'($urandom);
      stmem_tag_ready_v   = NT'($urandom);
      next_compute_tag_v  = ($urandom_range(0, 3) == 0) ? NT'($urandom) : '0;
      #1;
      n_cmp++; if ({block_ready, ldmem_ready, compute_ready, stmem_ready} !==
                   {tag_ready_v[m_alloc], ldmem_tag_ready_v[m_ld], compute_tag_ready_v[m_comp], stmem_tag_ready_v[m_st]})
        begin n_bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, {block_ready, ldmem_ready, compute_ready, stmem_ready},
          {tag_ready_v[m_alloc], ldmem_tag_ready_v[m_ld], compute_tag_ready_v[m_comp], stmem_tag_ready_v[m_st]}); end
      tick();
      n_cmp++; if ({tag_req_v, tag_reuse_v, tag_flush_v} !== {e_req, e_reuse, e_flush})
        begin n_bad++; $display("FAIL rnd_alloc[%0d]: got %b want %b", i, {tag_req_v, tag_reuse_v, tag_flush_v}, {e_req, e_reuse, e_flush}); end
      n_cmp++; if ({ldmem_tag_done_v, compute_tag_done_v, stmem_tag_done_v} !== {e_ld, e_cd, e_sd})
        begin n_bad++; $display("FAIL rnd_done[%0d]: got %b want %b", i, {ldmem_tag_done_v, compute_tag_done_v, stmem_tag_done_v}, {e_ld, e_cd, e_sd}); end
      n_cmp++; if (int'(ldmem_tag) !== m_ld || int'(compute_tag) !== m_comp || int'(stmem_tag) !== m_st)
        begin n_bad++; $display("FAIL rnd_tags[%0d]: got %0d%0d%0d want %0d%0d%0d", i, ldmem_tag, compute_tag, stmem_tag, m_ld, m_comp, m_st); end
      n_cmp++; if (int'(dut.cnt) !== m_cnt || idle !== (m_cnt == 0))
        begin n_bad++; $display("FAIL rnd_cnt[%0d]: got %0d/%b want %0d", i, dut.cnt, idle, m_cnt); end
      n_cmp++; if (protocol_err !== m_err)
        begin n_bad++; $display("FAIL rnd_err[%0d]: got %b want %b", i, protocol_err, m_err); end
    end
  endtask

  initial begin
    clear_inputs();
    reset_n = 0;
    model_reset();
    test_reset();
    test_alloc();
    test_ldmem();
    test_reuse();
    test_store_disabled();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
